dmem_responder: RTL and testbench

// - Memory-side responder for the core's data-memory request/response interface.
// - Services one load or store at a time with a valid/ready handshake and a fixed, parameterised wait-state count.
// - Sits between cpu and a word-organised byte-enabled RAM; used to exercise multi-cycle memory stalls in the pipeline.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_t   : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   BYTES_PER_WORD : bytes per memory word (one byte lane each)
//   addr_err()     : 1 when a byte address is misaligned or outside the memory
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int BYTES_PER_WORD = 4;

    // Addresses are widened to 64 bits so one helper serves any ADDR_WIDTH
    // up to 64 and any memory size.
    function automatic logic addr_err(input logic [63:0] addr, input logic [63:0] size);
        return (addr[1:0] != 2'b00) || (addr >= size);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous byte-enabled word RAM, one 8-bit RAM per byte lane.
//   clk   : clock, rising edge
//   we    : write strobe for the word at widx
//   be    : per-lane write enables, bit i -> wdata[8i+7:8i]
//   widx  : word index, used for both read and write
//   wdata : write data
//   rdata : registered read of mem[widx] (old data when written on the same edge)
// No reset: contents power up undefined.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        widx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int DEPTH = 2 ** IDX_W;

    // Splitting the word into independent lane RAMs keeps each array a plain
    // single-write-port memory that maps onto block RAM without byte-write support.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[widx] <= wdata[8*gi +: 8];
                end
                rdata[8*gi +: 8] <= lane_mem[widx];
            end
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data-memory interface. Services one
// load or store at a time with a fixed LATENCY wait-state count.
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready  : request handshake; req_ready is high only in IDLE
//   req_we               : 1 = store, 0 = load
//   req_addr             : byte address (word aligned, below DMEM_SIZE)
//   req_wdata / req_be   : store data and byte-lane enables
//   rsp_valid/rsp_ready  : response handshake; response held until accepted
//   rsp_rdata            : load data (0 for stores and errors)
//   rsp_err              : misaligned or out-of-range access
// A request accepted at edge k raises rsp_valid at edge k+1+LATENCY.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DMEM_SIZE  = 4096,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int OFF_W = $clog2(BYTES_PER_WORD);
    localparam int IDX_W = $clog2(DMEM_SIZE) - OFF_W;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = 4;

    dmem_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  err_reg;

    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [BE_W-1:0]       be_reg;

    logic                  commit;
    logic                  cur_err;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // FSM state, wait counter and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (commit) begin
                err_reg <= cur_err;
            end
        end
    end

    // Request latch: only meaningful between accept and response, so no reset.
    always_ff @(posedge clk) begin
        if (state_reg == IDLE && req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
        end
    end

    // The accept edge always lands in WAIT; WAIT then counts LATENCY edges
    // down to zero, and the edge that leaves it is the RAM commit edge.
    // This gives the k+1+LATENCY response timing for every LATENCY including 0.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    cnt_next   = CNT_W'(LATENCY);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cur_err = addr_err(64'(addr_reg), 64'(DMEM_SIZE));

    // Read is performed every cycle at the latched index; in RESP the index is
    // stable and no write occurs, so mem_rdata stays constant while held.
    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && we_reg && !cur_err),
        .be    (be_reg),
        .widx  (addr_reg[IDX_W+OFF_W-1:OFF_W]),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = rsp_valid && err_reg;
    assign rsp_rdata = (rsp_valid && !we_reg && !err_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{2, 4, 0};

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst       [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_we    [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic [3:0]  req_be    [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];

    exp_t sb[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            dmem_responder #(
                .ADDR_WIDTH (32),
                .DATA_WIDTH (32),
                .DMEM_SIZE  (4096),
                .LATENCY    (LAT[gi])
            ) dut (
                .clk       (clk),
                .rst       (rst[gi]),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_we    (req_we[gi]),
                .req_addr  (req_addr[gi]),
                .req_wdata (req_wdata[gi]),
                .req_be    (req_be[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_ready (rsp_ready[gi]),
                .rsp_rdata (rsp_rdata[gi]),
                .rsp_err   (rsp_err[gi])
            );
        end
    endgenerate

    // Drive one request; returns on the falling edge after the accept edge.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk);
        checks++;
        if (req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready dut%0d: req_ready=%b required 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        @(negedge clk);
        acc_cyc      = cyc;
        req_valid[d] = 1'b0;
        $display("dut%0d accept we=%0b addr=0x%08h wdata=0x%08h be=%b", d, we, addr, wdata, be);
    endtask

    // Wait for the response, check latency/data against the scoreboard,
    // optionally hold rsp_ready low for 'hold' cycles, then handshake.
    task automatic collect(input int d, input int hold);
        exp_t        e;
        int          n = 0;
        logic [31:0] first;
        logic        ok;
        while (rsp_valid[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid[d] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid=%b required 1 within 50 cycles", d, rsp_valid[d]);
            return;
        end
        checks++;
        if (cyc - acc_cyc !== LAT[d] + 1) begin
            errors++;
            $display("FAIL latency dut%0d: %0d cycles required %0d", d, cyc - acc_cyc, LAT[d] + 1);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard dut%0d: response with no expected entry", d);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (rsp_rdata[d] !== e.rdata || rsp_err[d] !== e.err) begin
            errors++;
            $display("FAIL rsp_data dut%0d: rdata=0x%08h err=%b required rdata=0x%08h err=%b",
                     d, rsp_rdata[d], rsp_err[d], e.rdata, e.err);
        end
        $display("dut%0d response rdata=0x%08h err=%b latency=%0d", d, rsp_rdata[d], rsp_err[d], cyc - acc_cyc);
        first = rsp_rdata[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ok = (rsp_valid[d] === 1'b1) && (rsp_rdata[d] === first) &&
                 (rsp_err[d] === e.err) && (req_ready[d] === 1'b0);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL hold_stable dut%0d cycle %0d: valid=%b rdata=0x%08h ready=%b required 1/0x%08h/0",
                         d, i, rsp_valid[d], rsp_rdata[d], req_ready[d], first);
            end
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        checks++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL release dut%0d: rsp_valid=%b req_ready=%b required 0/1", d, rsp_valid[d], req_ready[d]);
        end
    endtask

    task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        issue(d, we, addr, wdata, be);
        collect(d, hold);
    endtask

    // Watch for any spurious response over a few cycles.
    task automatic expect_quiet(input int d, input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid[d] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s dut%0d: rsp_valid seen 1 required 0", name, d);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0 || rsp_rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b valid=%b err=%b rdata=0x%08h required 1/0/0/0",
                     req_ready[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]);
        end
        // Start a load, then assert reset between clock edges while in WAIT.
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        #2 rst[0] = 1'b1;
        #1;
        checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ready=%b valid=%b err=%b required 1/0/0",
                     req_ready[0], rsp_valid[0], rsp_err[0]);
        end
        $display("dut0 async reset asserted mid-cycle");
        @(negedge clk);
        rst[0] = 1'b0;
        expect_quiet(0, "reset_no_rsp");
    endtask

    task automatic test_store_load();
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0);
    endtask

    task automatic test_byte_enable();
        txn(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0, 0);
    endtask

    task automatic test_errors();
        txn(0, 1'b1, 32'h0, 32'h11223344, 4'hF, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 0);
        txn(0, 1'b1, 32'h0, 32'h99999999, 4'h0, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h11223344, 1'b0, 0);
    endtask

    task automatic test_back_pressure();
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAABEEF, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [4];
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            txn(0, 1'b1, 32'h100 + 32'(4 * i), data[i], 4'hF, 32'h0, 1'b0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            txn(0, 1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, data[i], 1'b0, 0);
        end
    endtask

    task automatic test_reset_mid_store();
        txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 0);
        issue(1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #2 rst[1] = 1'b1;
        $display("dut1 reset pulse during store wait");
        @(negedge clk);
        rst[1] = 1'b0;
        expect_quiet(1, "mid_store_no_rsp");
        txn(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0);
    endtask

    task automatic test_latency0();
        txn(2, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 0);
        txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 2);
        txn(2, 1'b0, 32'h41, 32'h0, 4'h0, 32'h0, 1'b1, 0);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            req_be[i]    = '0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;
        @(negedge clk);

        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_store();
        test_latency0();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
